// File: rtl/network_2_3_3_3_3_8.sv
// Three-layer fixed-weight MLP (2 -> 3 -> 3 -> 3) over a valid/ready word stream.
// Each layer is an independent handshaked stage, so successive vectors overlap.

module nn_layer #(
    parameter int IN    = 2,
    parameter int OUT   = 3,
    parameter int P     = 3,
    parameter int T     = 8,
    parameter int LAYER = 1,
    parameter int RELU  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [IN*T-1:0]   i_in_vec,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [OUT*T-1:0]  o_out_vec
);
    localparam int ACC_W = 2 * T + 4;
    localparam int NG    = (OUT + P - 1) / P;
    localparam int KW    = (IN > 1) ? $clog2(IN) : 1;
    localparam int GW    = (NG > 1) ? $clog2(NG) : 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (T - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (T - 1)));

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

    state_t                  r_state;
    logic [KW-1:0]           r_k;
    logic [GW-1:0]           r_g;
    logic signed [T-1:0]     r_in   [IN];
    logic signed [ACC_W-1:0] r_acc  [P];
    logic signed [T-1:0]     r_res  [OUT];
    logic signed [T-1:0]     r_out  [OUT];
    logic                    r_out_valid;

    logic signed [ACC_W-1:0] w_sum  [P];
    logic signed [T-1:0]     w_res_next [OUT];
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_prod;
    int unsigned             w_idx;

    function automatic logic signed [T-1:0] w_rom(input int unsigned i, input int unsigned j);
        int v;
        v = 0;
        case (LAYER)
            1: case ({i[1:0], j[1:0]})
                4'b00_00: v = 1;   4'b00_01: v = -1;
                4'b01_00: v = 2;   4'b01_01: v = 1;
                4'b10_00: v = -1;  4'b10_01: v = 3;
                default:  v = 0;
            endcase
            2: case ({i[1:0], j[1:0]})
                4'b00_00: v = 1;   4'b00_10: v = 1;
                4'b01_01: v = 1;   4'b01_10: v = -1;
                4'b10_00: v = 1;   4'b10_01: v = 1;   4'b10_10: v = 1;
                default:  v = 0;
            endcase
            default: case ({i[1:0], j[1:0]})
                4'b00_00: v = 2;   4'b00_10: v = -1;
                4'b01_00: v = 1;   4'b01_01: v = 1;
                4'b10_01: v = -1;  4'b10_10: v = 1;
                default:  v = 0;
            endcase
        endcase
        return T'(v);
    endfunction

    // Saturate the full-precision sum once, then optionally rectify.
    function automatic logic signed [T-1:0] act(input logic signed [ACC_W-1:0] a);
        logic signed [T-1:0] s;
        if (a > SAT_HI)      s = SAT_HI[T-1:0];
        else if (a < SAT_LO) s = SAT_LO[T-1:0];
        else                 s = a[T-1:0];
        if (RELU != 0 && s[T-1]) s = '0;
        return s;
    endfunction

    always_comb begin
        w_res_next = r_res;
        w_base     = '0;
        w_prod     = '0;
        w_idx      = 0;
        for (int unsigned p = 0; p < P; p++) begin
            w_sum[p] = '0;
            w_idx    = int'(r_g) * P + p;
            if (w_idx < OUT) begin
                w_base   = (r_k == '0) ? '0 : r_acc[p];
                w_prod   = ACC_W'(w_rom(w_idx, int'(r_k))) * ACC_W'(r_in[r_k]);
                w_sum[p] = w_base + w_prod;
                w_res_next[w_idx] = act(w_sum[p]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_g         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_in_valid) begin
                    for (int unsigned i = 0; i < IN; i++) r_in[i] <= i_in_vec[i*T +: T];
                    r_k     <= '0;
                    r_g     <= '0;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    for (int unsigned p = 0; p < P; p++) r_acc[p] <= w_sum[p];
                    if (r_k == KW'(IN - 1)) begin
                        r_res <= w_res_next;
                        r_k   <= '0;
                        if (r_g == GW'(NG - 1)) r_state <= S_HOLD;
                        else                    r_g     <= r_g + 1'b1;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: if (!r_out_valid || i_out_ready) begin
                    r_out       <= r_res;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = r_out_valid;

    always_comb begin
        o_out_vec = '0;
        for (int unsigned i = 0; i < OUT; i++) o_out_vec[i*T +: T] = r_out[i];
    end
endmodule

module network_2_3_3_3_3_8 #(
    parameter int N  = 2,
    parameter int M1 = 3,
    parameter int M2 = 3,
    parameter int M3 = 3,
    parameter int P  = 3,
    parameter int T  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    input  logic         m_ready,
    input  logic [T-1:0] data_in,
    output logic         m_valid,
    output logic         s_ready,
    output logic [T-1:0] data_out
);
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (M3 > 1) ? $clog2(M3) : 1;

    logic              r_started;
    logic [NW-1:0]     r_cnt;
    logic [N*T-1:0]    r_xvec;
    logic              r_xfull;
    logic [M3*T-1:0]   r_yvec;
    logic              r_yfull;
    logic [CW-1:0]     r_idx;

    logic              w_l1_ready, w_l1_valid, w_l2_ready, w_l2_valid, w_l3_ready, w_l3_valid;
    logic [M1*T-1:0]   w_h1;
    logic [M2*T-1:0]   w_h2;
    logic [M3*T-1:0]   w_y;

    // Words are assembled in place; layer 1 has already captured r_xvec before s_ready reopens.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_started <= 1'b0;
            r_cnt     <= '0;
            r_xfull   <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (r_xfull && w_l1_ready) r_xfull <= 1'b0;
            if (s_valid && s_ready) begin
                r_xvec[r_cnt*T +: T] <= data_in;
                if (r_cnt == NW'(N - 1)) begin
                    r_cnt   <= '0;
                    r_xfull <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign s_ready = r_started && !r_xfull;

    nn_layer #(.IN(N), .OUT(M1), .P(P), .T(T), .LAYER(1), .RELU(1)) u_l1 (
        .clk(clk), .reset(reset),
        .i_in_valid(r_xfull), .o_in_ready(w_l1_ready), .i_in_vec(r_xvec),
        .o_out_valid(w_l1_valid), .i_out_ready(w_l2_ready), .o_out_vec(w_h1)
    );

    nn_layer #(.IN(M1), .OUT(M2), .P(P), .T(T), .LAYER(2), .RELU(1)) u_l2 (
        .clk(clk), .reset(reset),
        .i_in_valid(w_l1_valid), .o_in_ready(w_l2_ready), .i_in_vec(w_h1),
        .o_out_valid(w_l2_valid), .i_out_ready(w_l3_ready), .o_out_vec(w_h2)
    );

    nn_layer #(.IN(M2), .OUT(M3), .P(P), .T(T), .LAYER(3), .RELU(0)) u_l3 (
        .clk(clk), .reset(reset),
        .i_in_valid(w_l2_valid), .o_in_ready(w_l3_ready), .i_in_vec(w_h2),
        .o_out_valid(w_l3_valid), .i_out_ready(!r_yfull), .o_out_vec(w_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_yfull <= 1'b0;
            r_idx   <= '0;
        end else if (!r_yfull) begin
            if (w_l3_valid) begin
                r_yvec  <= w_y;
                r_yfull <= 1'b1;
                r_idx   <= '0;
            end
        end else if (m_ready) begin
            if (r_idx == CW'(M3 - 1)) begin
                r_yfull <= 1'b0;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign m_valid  = r_yfull;
    assign data_out = r_yvec[r_idx*T +: T];
endmodule

// File: tb/tb_network_2_3_3_3_3_8.sv
// Randomised stream bench for network_2_3_3_3_3_8 against an integer model of the MLP.

module tb_network_2_3_3_3_3_8;
    logic       clk = 1'b0;
    logic       reset, s_valid, m_ready;
    logic [7:0] data_in;
    logic       m_valid, s_ready;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_errors = 0;
    int in_q[$];
    int exp_q[$];
    int got_q[$];
    int stab_err;
    logic sready_hold_end;

    always #5 clk = ~clk;

    network_2_3_3_3_3_8 #(.N(2), .M1(3), .M2(3), .M3(3), .P(3), .T(8)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .m_ready(m_ready),
        .data_in(data_in), .m_valid(m_valid), .s_ready(s_ready), .data_out(data_out)
    );

    function automatic int sat8(int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    function automatic void ref_net(input int x0, input int x1, output int y0, output int y1, output int y2);
        int w1[3][2];
        int w2[3][3];
        int w3[3][3];
        int x[2];
        int h1[3];
        int h2[3];
        int y[3];
        int s;
        w1 = '{'{1, -1}, '{2, 1}, '{-1, 3}};
        w2 = '{'{1, 0, 1}, '{0, 1, -1}, '{1, 1, 1}};
        w3 = '{'{2, 0, -1}, '{1, 1, 0}, '{0, -1, 1}};
        x[0] = x0;
        x[1] = x1;
        for (int i = 0; i < 3; i++) begin
            s = 0;
            for (int j = 0; j < 2; j++) s += w1[i][j] * x[j];
            h1[i] = (sat8(s) < 0) ? 0 : sat8(s);
        end
        for (int i = 0; i < 3; i++) begin
            s = 0;
            for (int j = 0; j < 3; j++) s += w2[i][j] * h1[j];
            h2[i] = (sat8(s) < 0) ? 0 : sat8(s);
        end
        for (int i = 0; i < 3; i++) begin
            s = 0;
            for (int j = 0; j < 3; j++) s += w3[i][j] * h2[j];
            y[i] = sat8(s);
        end
        y0 = y[0];
        y1 = y[1];
        y2 = y[2];
    endfunction

    task automatic push_vec(input int x0, input int x1);
        int y0, y1, y2;
        in_q.push_back(x0);
        in_q.push_back(x1);
        ref_net(x0, x1, y0, y1, y2);
        exp_q.push_back(y0);
        exp_q.push_back(y1);
        exp_q.push_back(y2);
    endtask

    function automatic int rand_word();
        int r;
        r = int'($urandom_range(7));
        if (r == 0) return 127;
        if (r == 1) return -128;
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic clear_queues();
        in_q.delete();
        exp_q.delete();
        got_q.delete();
    endtask

    // Drives in_q word by word and collects n_out outputs; inputs change at negedge,
    // handshakes are evaluated 1 time unit later and take effect at the next posedge.
    task automatic drive_stream(input int pv, input int pr, input int hold, input int n_out,
                                input int max_cycles, output int cycles, output int lat,
                                output bit timeout);
        int   acc_words;
        int   c_in;
        int   c_out;
        bit   prev_stall;
        logic [7:0] prev_d;
        acc_words = 0; c_in = -1; c_out = -1; prev_stall = 0; prev_d = '0;
        cycles = 0; timeout = 0; stab_err = 0; sready_hold_end = 1'b1;
        got_q.delete();
        while (in_q.size() > 0 || got_q.size() < n_out) begin
            if (cycles >= max_cycles) begin
                timeout = 1;
                break;
            end
            @(negedge clk);
            s_valid = (in_q.size() > 0) && (int'($urandom_range(99)) < pv);
            data_in = s_valid ? 8'(in_q[0]) : 8'($urandom);
            m_ready = (cycles >= hold) && (int'($urandom_range(99)) < pr);
            #1;
            if (prev_stall && (!m_valid || data_out !== prev_d)) stab_err++;
            prev_stall = m_valid && !m_ready;
            prev_d     = data_out;
            if (cycles == hold - 1) sready_hold_end = s_ready;
            if (s_valid && s_ready) begin
                void'(in_q.pop_front());
                acc_words++;
                if (acc_words == 2 && c_in < 0) c_in = cycles;
            end
            if (m_valid && c_out < 0) c_out = cycles;
            if (m_valid && m_ready) got_q.push_back(int'($signed(data_out)));
            @(posedge clk);
            cycles++;
        end
        lat = c_out - c_in;
        #1;
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin n_errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
        n_checks++;
        if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_s_ready: got %b expected 1", s_ready); end
        n_checks++;
        if (m_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_m_valid: got %b expected 0", m_valid); end
    endtask

    task automatic test_directed();
        int exp_tab[12];
        int cyc, lat;
        bit to;
        exp_tab = '{-5, 9, 2, 127, 127, 1, 0, 0, 0, 2, 3, 4};
        clear_queues();
        push_vec(3, 1);
        push_vec(127, -128);
        push_vec(-5, -5);
        push_vec(0, 1);
        drive_stream(100, 100, 0, 12, 2000, cyc, lat, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL directed_timeout: got %0d outputs expected 12", got_q.size()); end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_tab[i]) begin
                n_errors++;
                $display("FAIL directed_y[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 9999, exp_tab[i]);
            end
        end
        n_checks++;
        if (lat < 0 || lat > 20) begin n_errors++; $display("FAIL first_output_latency: got %0d cycles expected <= 20", lat); end
    endtask

    task automatic test_back_to_back();
        int cyc, lat;
        bit to;
        clear_queues();
        for (int v = 0; v < 20; v++) push_vec(rand_word(), rand_word());
        drive_stream(100, 100, 0, 60, 1000, cyc, lat, to);
        n_checks++;
        if (to || cyc > 20 * 8 + 20) begin
            n_errors++;
            $display("FAIL throughput: got %0d cycles for 20 vectors expected <= 180", cyc);
        end
        for (int i = 0; i < 60; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL b2b_y[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 9999, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int cyc, lat;
        bit to;
        clear_queues();
        for (int v = 0; v < 5000; v++) push_vec(rand_word(), rand_word());
        drive_stream(50, 50, 0, 15000, 80000, cyc, lat, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL random_timeout: got %0d outputs expected 15000", got_q.size()); end
        n_checks++;
        if (stab_err !== 0) begin n_errors++; $display("FAIL random_stall_stability: got %0d violations expected 0", stab_err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL random_y[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 9999, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int cyc, lat, seen;
        bit to;
        int exp_tab[3];
        exp_tab = '{-5, 9, 2};
        clear_queues();
        in_q.push_back(3);
        drive_stream(100, 100, 0, 0, 100, cyc, lat, to);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (to || m_valid !== 1'b0) begin n_errors++; $display("FAIL partial_wait: got m_valid %b expected 0", m_valid); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);

        clear_queues();
        push_vec(7, 7);
        drive_stream(100, 100, 0, 1, 200, cyc, lat, to);
        n_checks++;
        if (to || got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
            n_errors++;
            $display("FAIL partial_discard: got %0d expected %0d", (got_q.size() > 0) ? got_q[0] : 9999, exp_q[0]);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (m_valid !== 1'b0) begin n_errors++; $display("FAIL mid_output_reset_m_valid: got %b expected 0", m_valid); end
        reset = 1'b0;
        @(posedge clk);

        clear_queues();
        push_vec(3, 1);
        drive_stream(100, 100, 0, 3, 200, cyc, lat, to);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (to || i >= got_q.size() || got_q[i] !== exp_tab[i]) begin
                n_errors++;
                $display("FAIL after_abort_y[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 9999, exp_tab[i]);
            end
        end
        seen = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        m_ready = 1'b0;
        n_checks++;
        if (seen !== 0) begin n_errors++; $display("FAIL stale_output: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_backpressure();
        int cyc, lat;
        bit to;
        clear_queues();
        for (int v = 0; v < 12; v++) push_vec(rand_word(), rand_word());
        drive_stream(100, 100, 50, 36, 2000, cyc, lat, to);
        n_checks++;
        if (sready_hold_end !== 1'b0) begin n_errors++; $display("FAIL full_s_ready: got %b expected 0", sready_hold_end); end
        n_checks++;
        if (stab_err !== 0) begin n_errors++; $display("FAIL hold_stability: got %0d violations expected 0", stab_err); end
        n_checks++;
        if (to) begin n_errors++; $display("FAIL backpressure_timeout: got %0d outputs expected 36", got_q.size()); end
        for (int i = 0; i < 36; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL backpressure_y[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 9999, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
